conv_idx_seq: RTL and testbench

// - Index/address sequencer for the 1-D convolution core: z[i] = sum_j x[j]*y[i-j].
// - Walks outer index i (0..sz_x+sz_y-2) and inner index j (0..sz_x-1); drives X/Y/Z memory

---
 rtl/conv_idx_seq_pkg.sv | 16 +
 rtl/conv_term_cmp.sv | 17 +
 rtl/conv_idx_seq.sv | 122 ++++++++++++
 tb/tb_conv_idx_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/conv_idx_seq_pkg.sv
// Shared constants and state encoding for the convolution index sequencer.
package conv_idx_seq_pkg;

    localparam int unsigned SZ_W   = 5;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned DIFF_W = IDX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_MAC  = 3'd2,
        ST_WRZ  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/conv_term_cmp.sv
// Terminal-count compares for the inner (j) and outer (i) loop indices.
module conv_term_cmp
    import conv_idx_seq_pkg::*;
(
    input  logic [IDX_W-1:0] i,
    input  logic [IDX_W-1:0] j,
    input  logic [SZ_W-1:0]  sz_x,
    input  logic [SZ_W-1:0]  sz_y,
    output logic             j_last,
    output logic             i_last
);

    // Sizes are widened before subtracting so 31+31-2 = 60 fits without wrap.
    assign j_last = (j == (IDX_W'(sz_x) - IDX_W'(1)));
    assign i_last = (i == (IDX_W'(sz_x) + IDX_W'(sz_y) - IDX_W'(2)));

endmodule

// File: rtl/conv_idx_seq.sv
// Index/address sequencer driving X/Y/Z addresses and MAC strobes for 1-D convolution.
module conv_idx_seq
    import conv_idx_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [SZ_W-1:0]  sz_x,
    input  logic [SZ_W-1:0]  sz_y,
    output logic [SZ_W-1:0]  addr_x,
    output logic [SZ_W-1:0]  addr_y,
    output logic [IDX_W-1:0] addr_z,
    output logic             mac_en,
    output logic             clr_acc,
    output logic             wr_z,
    output logic             busy,
    output logic             done
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [SZ_W-1:0]   szx_q, szx_d;
    logic [SZ_W-1:0]   szy_q, szy_d;
    logic [DIFF_W-1:0] diff;
    logic              j_last;
    logic              i_last;

    // One extra bit keeps i-j from wrapping when j > i.
    assign diff = {1'b0, i_q} - {1'b0, j_q};

    conv_term_cmp u_term_cmp (
        .i      (i_q),
        .j      (j_q),
        .sz_x   (szx_q),
        .sz_y   (szy_q),
        .j_last (j_last),
        .i_last (i_last)
    );

    // State, counter and size-latch registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            szx_q   <= '0;
            szy_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            szx_q   <= szx_d;
            szy_q   <= szy_d;
        end
    end

    // Next-state, counter updates and Moore output decode.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        szx_d   = szx_q;
        szy_d   = szy_q;
        addr_x  = '0;
        addr_y  = '0;
        addr_z  = '0;
        mac_en  = 1'b0;
        clr_acc = 1'b0;
        wr_z    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    szx_d   = sz_x;
                    szy_d   = sz_y;
                    i_d     = '0;
                    state_d = ((sz_x == '0) || (sz_y == '0)) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR: begin
                busy    = 1'b1;
                clr_acc = 1'b1;
                j_d     = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                busy   = 1'b1;
                addr_x = SZ_W'(j_q);
                addr_y = diff[SZ_W-1:0];
                mac_en = (i_q >= j_q) && (diff < DIFF_W'(szy_q));
                if (j_last) begin
                    state_d = ST_WRZ;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            ST_WRZ: begin
                busy   = 1'b1;
                wr_z   = 1'b1;
                addr_z = i_q;
                if (i_last) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + IDX_W'(1);
                    state_d = ST_CLR;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_idx_seq.sv
// Self-checking bench for conv_idx_seq: per-cycle trace against a loop-nest model.
module tb_conv_idx_seq;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [4:0] sz_x;
    logic [4:0] sz_y;
    logic [4:0] addr_x;
    logic [4:0] addr_y;
    logic [5:0] addr_z;
    logic       mac_en;
    logic       clr_acc;
    logic       wr_z;
    logic       busy;
    logic       done;

    logic [20:0] act_bus;
    logic [20:0] expq[$];

    int passed;
    int total;

    typedef struct {
        int sx;
        int sy;
        int wr;
        int mac;
        int dcyc;
        bit noise;
    } vec_t;

    vec_t tbl[7];

    conv_idx_seq dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .sz_x    (sz_x),
        .sz_y    (sz_y),
        .addr_x  (addr_x),
        .addr_y  (addr_y),
        .addr_z  (addr_z),
        .mac_en  (mac_en),
        .clr_acc (clr_acc),
        .wr_z    (wr_z),
        .busy    (busy),
        .done    (done)
    );

    assign act_bus = {busy, done, wr_z, clr_acc, mac_en, addr_z, addr_y, addr_x};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    endtask

    // Expected per-cycle outputs straight from the convolution loop nest.
    task automatic build(input int sx, input int sy);
        expq.delete();
        if (sx == 0 || sy == 0) begin
            expq.push_back({1'b1, 1'b1, 19'd0});
        end else begin
            for (int i = 0; i <= sx + sy - 2; i++) begin
                expq.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
                for (int j = 0; j < sx; j++) begin
                    int d;
                    d = i - j;
                    expq.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'((d >= 0) && (d < sy)),
                                    6'd0, 5'(d), 5'(j)});
                end
                expq.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'(i), 10'd0});
            end
            expq.push_back({1'b1, 1'b1, 19'd0});
        end
    endtask

    // Entry/exit phase: just after a rising edge, DUT idle.
    task automatic run_seq(input int sx, input int sy, input bit noise, input int abort_at,
                           input int exp_wr, input int exp_mac, input int exp_done);
        int wr_n;
        int mac_n;
        int done_at;
        int n;
        build(sx, sy);
        n       = expq.size();
        wr_n    = 0;
        mac_n   = 0;
        done_at = -1;
        start = 1'b1;
        sz_x  = 5'(sx);
        sz_y  = 5'(sy);
        @(posedge clk); #1;
        start = 1'b0;
        if (noise) begin
            sz_x = 5'($urandom);
            sz_y = 5'($urandom);
        end
        for (int idx = 0; idx < n; idx++) begin
            @(negedge clk);
            chk($sformatf("trace_%0dx%0d_c%0d", sx, sy, idx + 1), 32'(act_bus), 32'(expq[idx]));
            if (wr_z) wr_n++;
            if (mac_en) mac_n++;
            if (done) done_at = idx + 1;
            if (abort_at == idx + 1) begin
                rstn  = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                chk("mid_reset_outputs", 32'(act_bus), 32'd0);
                rstn = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                chk("post_reset_idle", 32'(act_bus), 32'd0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (noise && idx < n - 1) begin
                start = 1'($urandom);
                sz_x  = 5'($urandom);
                sz_y  = 5'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk($sformatf("wr_count_%0dx%0d", sx, sy), 32'(wr_n), 32'(exp_wr));
        chk($sformatf("mac_count_%0dx%0d", sx, sy), 32'(mac_n), 32'(exp_mac));
        chk($sformatf("done_cycle_%0dx%0d", sx, sy), 32'(done_at), 32'(exp_done));
        @(negedge clk);
        chk($sformatf("idle_after_%0dx%0d", sx, sy), 32'(act_bus), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        tbl[0] = '{sx: 1,  sy: 1,  wr: 1,  mac: 1,   dcyc: 4,    noise: 1'b0};
        tbl[1] = '{sx: 3,  sy: 2,  wr: 4,  mac: 6,   dcyc: 21,   noise: 1'b0};
        tbl[2] = '{sx: 0,  sy: 5,  wr: 0,  mac: 0,   dcyc: 1,    noise: 1'b0};
        tbl[3] = '{sx: 4,  sy: 0,  wr: 0,  mac: 0,   dcyc: 1,    noise: 1'b0};
        tbl[4] = '{sx: 2,  sy: 5,  wr: 6,  mac: 10,  dcyc: 25,   noise: 1'b1};
        tbl[5] = '{sx: 5,  sy: 1,  wr: 5,  mac: 5,   dcyc: 36,   noise: 1'b0};
        tbl[6] = '{sx: 31, sy: 31, wr: 61, mac: 961, dcyc: 2014, noise: 1'b1};

        rstn  = 1'b0;
        start = 1'b1;
        sz_x  = 5'd3;
        sz_y  = 5'd2;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("reset_outputs", 32'(act_bus), 32'd0);
        end
        @(posedge clk); #1;
        rstn  = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            run_seq(tbl[k].sx, tbl[k].sy, tbl[k].noise, 0, tbl[k].wr, tbl[k].mac, tbl[k].dcyc);
        end

        // Reset lands during MAC of i=2 (cycle 15 of a 4x4 run), then a clean rerun.
        run_seq(4, 4, 1'b0, 15, 0, 0, 0);
        run_seq(4, 4, 1'b0, 0, 7, 16, 43);

        repeat (6) begin
            int sx;
            int sy;
            int ew;
            int ed;
            sx = int'($urandom_range(0, 12));
            sy = int'($urandom_range(0, 12));
            ew = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
            ed = (sx == 0 || sy == 0) ? 1 : (sx + sy - 1) * (sx + 2) + 1;
            run_seq(sx, sy, 1'b1, 0, ew, sx * sy, ed);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
